// File: rtl/layer_compositor_if.sv
// Pixel-stream and descriptor bundle between the video source and the layer compositor.
interface layer_compositor_if #(
    parameter int NUM_OBJ  = 5,
    parameter int DESC_W   = 26,
    parameter int COLOR_W  = 12,
    parameter int OFFSET_W = 11
);
    logic                        vsync;
    logic                        blank;
    logic [9:0]                  vcount;
    logic [9:0]                  wave_prof;
    logic [9:0]                  p_vpos;
    logic [NUM_OBJ*DESC_W-1:0]   p_obj;
    logic [NUM_OBJ-1:0]          obj_en;
    logic [COLOR_W-1:0]          char_rgb;
    logic [NUM_OBJ*COLOR_W-1:0]  obj_rgb;
    logic [COLOR_W-1:0]          sky_rgb;

    logic [9:0]                  vpos_q;
    logic [NUM_OBJ*DESC_W-1:0]   obj_q;
    logic [OFFSET_W-1:0]         parallax_offset;
    logic [NUM_OBJ-1:0]          collide;
    logic                        collide_valid;
    logic [COLOR_W-1:0]          p_rgb;

    modport master (
        output vsync, blank, vcount, wave_prof, p_vpos, p_obj, obj_en,
               char_rgb, obj_rgb, sky_rgb,
        input  vpos_q, obj_q, parallax_offset, collide, collide_valid, p_rgb
    );

    modport slave (
        input  vsync, blank, vcount, wave_prof, p_vpos, p_obj, obj_en,
               char_rgb, obj_rgb, sky_rgb,
        output vpos_q, obj_q, parallax_offset, collide, collide_valid, p_rgb
    );
endinterface

// File: rtl/layer_compositor.sv
// Layer compositor: merges character, object sprites, sky and water into one
// pixel per vclock through a 2-stage pipeline, latches object descriptors at
// frame start, drives the parallax scroll and reports per-frame collisions.
// The interface instance must use the same NUM_OBJ/DESC_W/COLOR_W/OFFSET_W.
module layer_compositor #(
    parameter int NUM_OBJ     = 5,
    parameter int DESC_W      = 26,
    parameter int COLOR_W     = 12,
    parameter int OFFSET_W    = 11,
    parameter int PAR_DIV_LOG = 3,
    parameter logic [COLOR_W-1:0] WATER_RGB = 12'h00F,
    parameter logic [COLOR_W-1:0] FILL_RGB  = 12'hF0F
) (
    input  logic          vclock,
    input  logic          reset_n,
    layer_compositor_if.slave bus
);
    localparam logic [9:0] VPOS_RESET = 10'd384;
    // Water is a permanent layer, so the fill colour is held in reserve only.
    localparam logic       WATER_EN   = 1'b1;

    logic                       vs_d;
    logic                       frame_start;
    logic [PAR_DIV_LOG-1:0]     div;
    logic [NUM_OBJ-1:0]         hit;
    logic [NUM_OBJ-1:0]         hit_now;
    logic [NUM_OBJ-1:0]         slot_live;

    logic                       blank_s1;
    logic                       above_s1;
    logic [COLOR_W-1:0]         char_s1;
    logic [COLOR_W-1:0]         sky_s1;
    logic [NUM_OBJ*COLOR_W-1:0] obj_s1;
    logic [COLOR_W-1:0]         pix_next;
    logic                       obj_found;

    assign frame_start = vs_d & ~bus.vsync;

    // Remember last vsync so its falling edge can be seen in the vclock domain.
    always_ff @(posedge vclock) begin
        if (!reset_n) vs_d <= 1'b1;
        else          vs_d <= bus.vsync;
    end

    // Take a frame-stable copy of the character position and descriptors.
    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            bus.vpos_q <= VPOS_RESET;
            bus.obj_q  <= '0;
        end else if (frame_start) begin
            bus.vpos_q <= bus.p_vpos;
            bus.obj_q  <= bus.p_obj;
        end
    end

    // Advance the scroll offset on the first frame of every divider period.
    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            div                 <= '0;
            bus.parallax_offset <= '0;
        end else if (frame_start) begin
            div <= div + 1'b1;
            if (div == '0) bus.parallax_offset <= bus.parallax_offset + 1'b1;
        end
    end

    // A slot counts only when latched non-empty and enabled; a hit needs a visible overlap.
    always_comb begin
        slot_live = '0;
        hit_now   = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            slot_live[i] = (bus.obj_q[i*DESC_W +: DESC_W] != '0) && bus.obj_en[i];
            hit_now[i]   = slot_live[i] && !bus.blank && (bus.char_rgb != '0) &&
                           (bus.obj_rgb[i*COLOR_W +: COLOR_W] != '0);
        end
    end

    // Accumulate hits over a frame and publish them at the next frame start.
    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            hit               <= '0;
            bus.collide       <= '0;
            bus.collide_valid <= 1'b0;
        end else if (frame_start) begin
            bus.collide       <= hit;
            bus.collide_valid <= 1'b1;
            hit               <= '0;
        end else begin
            bus.collide_valid <= 1'b0;
            hit               <= hit | hit_now;
        end
    end

    // Stage 1: register the colour inputs and the above-water decision.
    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            blank_s1 <= 1'b0;
            above_s1 <= 1'b0;
            char_s1  <= '0;
            sky_s1   <= '0;
            obj_s1   <= '0;
        end else begin
            blank_s1 <= bus.blank;
            above_s1 <= (bus.vcount <= bus.wave_prof);
            char_s1  <= bus.char_rgb;
            sky_s1   <= bus.sky_rgb;
            obj_s1   <= bus.obj_rgb;
        end
    end

    // Stage 2 priority: blank, character, lowest live object, sky, water.
    always_comb begin
        pix_next  = WATER_EN ? WATER_RGB : FILL_RGB;
        obj_found = 1'b0;
        if (blank_s1) begin
            pix_next = '0;
        end else if (char_s1 != '0) begin
            pix_next = char_s1;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (!obj_found && slot_live[i] && (obj_s1[i*COLOR_W +: COLOR_W] != '0)) begin
                    pix_next  = obj_s1[i*COLOR_W +: COLOR_W];
                    obj_found = 1'b1;
                end
            end
            if (!obj_found && above_s1) pix_next = sky_s1;
        end
    end

    // Stage 2 register: the composited pixel.
    always_ff @(posedge vclock) begin
        if (!reset_n) bus.p_rgb <= '0;
        else          bus.p_rgb <= pix_next;
    end
endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus random
// traffic, all compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_layer_compositor;
    localparam int NUM_OBJ     = 5;
    localparam int DESC_W      = 26;
    localparam int COLOR_W     = 12;
    localparam int OFFSET_W    = 11;
    localparam int PAR_DIV_LOG = 3;
    localparam logic [COLOR_W-1:0] WATER = 12'h00F;

    logic vclock = 1'b0;
    logic reset_n;

    always #7.692 vclock = ~vclock;

    layer_compositor_if #(.NUM_OBJ(NUM_OBJ), .DESC_W(DESC_W), .COLOR_W(COLOR_W),
                          .OFFSET_W(OFFSET_W)) bus ();

    layer_compositor #(.NUM_OBJ(NUM_OBJ), .DESC_W(DESC_W), .COLOR_W(COLOR_W),
                       .OFFSET_W(OFFSET_W), .PAR_DIV_LOG(PAR_DIV_LOG),
                       .WATER_RGB(12'h00F), .FILL_RGB(12'hF0F)) dut (
        .vclock  (vclock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic                mVsPrev;
    logic [DESC_W-1:0]   mLatch [NUM_OBJ];
    logic [9:0]          mVpos;
    logic [NUM_OBJ-1:0]  mAcc;
    logic [NUM_OBJ-1:0]  mCollide;
    logic                mValid;
    int                  mFrames;
    logic [COLOR_W-1:0]  mPix;
    logic                rBlank, rAbove;
    logic [COLOR_W-1:0]  rChar, rSky;
    logic [COLOR_W-1:0]  rObj [NUM_OBJ];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Pixel a display would show for the inputs captured one clock earlier.
    function automatic logic [COLOR_W-1:0] resolvePixel();
        if (rBlank) return '0;
        if (rChar != '0) return rChar;
        for (int i = 0; i < NUM_OBJ; i++)
            if (mLatch[i] != '0 && bus.obj_en[i] && rObj[i] != '0) return rObj[i];
        return rAbove ? rSky : WATER;
    endfunction

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic modelEdge();
        logic fs;
        logic [NUM_OBJ-1:0] hits;
        if (!reset_n) begin
            mVsPrev = 1'b1;
            foreach (mLatch[i]) mLatch[i] = '0;
            mVpos = 10'd384; mAcc = '0; mCollide = '0; mValid = 1'b0;
            mFrames = 0; mPix = '0;
            rBlank = 1'b0; rAbove = 1'b0; rChar = '0; rSky = '0;
            foreach (rObj[i]) rObj[i] = '0;
        end else begin
            fs = mVsPrev && !bus.vsync;
            mPix = resolvePixel();
            hits = '0;
            for (int i = 0; i < NUM_OBJ; i++)
                if (mLatch[i] != '0 && bus.obj_en[i] && !bus.blank && bus.char_rgb != '0 &&
                    bus.obj_rgb[i*COLOR_W +: COLOR_W] != '0) hits[i] = 1'b1;
            if (fs) begin
                mCollide = mAcc; mValid = 1'b1; mAcc = '0;
                for (int i = 0; i < NUM_OBJ; i++) mLatch[i] = bus.p_obj[i*DESC_W +: DESC_W];
                mVpos = bus.p_vpos;
                mFrames++;
            end else begin
                mValid = 1'b0;
                mAcc = mAcc | hits;
            end
            rBlank = bus.blank;
            rAbove = (bus.vcount <= bus.wave_prof);
            rChar  = bus.char_rgb;
            rSky   = bus.sky_rgb;
            for (int i = 0; i < NUM_OBJ; i++) rObj[i] = bus.obj_rgb[i*COLOR_W +: COLOR_W];
            mVsPrev = bus.vsync;
        end
    endtask

    task automatic compareAll();
        checkOutput("p_rgb", 64'(bus.p_rgb), 64'(mPix));
        checkOutput("collide_valid", 64'(bus.collide_valid), 64'(mValid));
        checkOutput("collide", 64'(bus.collide), 64'(mCollide));
        checkOutput("parallax_offset", 64'(bus.parallax_offset),
                    64'(((mFrames + 7) / 8) % (1 << OFFSET_W)));
        checkOutput("vpos_q", 64'(bus.vpos_q), 64'(mVpos));
        for (int i = 0; i < NUM_OBJ; i++)
            checkOutput($sformatf("obj_q[%0d]", i), 64'(bus.obj_q[i*DESC_W +: DESC_W]), 64'(mLatch[i]));
    endtask

    // One clock: model the edge, let the DUT take it, compare on the falling edge.
    task automatic applyStimulus();
        modelEdge();
        @(posedge vclock);
        @(negedge vclock);
        compareAll();
    endtask

    task automatic stepN(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic frameStart();
        bus.vsync = 1'b1; applyStimulus();
        bus.vsync = 1'b0; applyStimulus();
    endtask

    task automatic setObjRgb(input int i, input logic [COLOR_W-1:0] c);
        bus.obj_rgb[i*COLOR_W +: COLOR_W] = c;
    endtask

    task automatic setDesc(input int i, input logic [DESC_W-1:0] d);
        bus.p_obj[i*DESC_W +: DESC_W] = d;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.vsync = 1'b1; bus.blank = 1'b1; bus.vcount = '0; bus.wave_prof = '0;
        bus.p_vpos = 10'd100; bus.p_obj = '0; bus.obj_en = '1;
        bus.char_rgb = '0; bus.obj_rgb = '0; bus.sky_rgb = '0;

        // Reset with vsync toggling
        for (int k = 0; k < 4; k++) begin
            bus.vsync = ~bus.vsync;
            applyStimulus();
        end
        checkOutput("reset_vpos", 64'(bus.vpos_q), 64'd384);
        checkOutput("reset_p_rgb", 64'(bus.p_rgb), 64'd0);
        checkOutput("reset_valid", 64'(bus.collide_valid), 64'd0);
        bus.vsync = 1'b1;
        reset_n = 1'b1;
        stepN(3);
        checkOutput("no_early_frame", 64'(bus.collide_valid), 64'd0);
        bus.vsync = 1'b0; applyStimulus();
        checkOutput("first_frame_valid", 64'(bus.collide_valid), 64'd1);
        stepN(3);
        checkOutput("held_low_no_pulse", 64'(bus.collide_valid), 64'd0);

        // Priority
        bus.p_obj = '0; setDesc(1, 26'h12345); setDesc(3, 26'h0ABCD);
        bus.p_vpos = 10'd200;
        frameStart();
        checkOutput("vpos_latched", 64'(bus.vpos_q), 64'd200);
        bus.blank = 1'b0; bus.char_rgb = '0; bus.obj_rgb = '0;
        setObjRgb(1, 12'h0F0); setObjRgb(3, 12'hF00);
        stepN(2);
        checkOutput("prio_slot1", 64'(bus.p_rgb), 64'h0F0);
        bus.obj_en[1] = 1'b0;
        stepN(2);
        checkOutput("prio_slot3", 64'(bus.p_rgb), 64'hF00);
        bus.char_rgb = 12'h123;
        stepN(2);
        checkOutput("prio_char", 64'(bus.p_rgb), 64'h123);

        // Background
        bus.char_rgb = '0; bus.obj_rgb = '0; bus.obj_en = '1;
        bus.wave_prof = 10'd300; bus.vcount = 10'd300; bus.sky_rgb = 12'hABC;
        stepN(2);
        checkOutput("bg_sky", 64'(bus.p_rgb), 64'hABC);
        bus.vcount = 10'd301;
        stepN(2);
        checkOutput("bg_water", 64'(bus.p_rgb), 64'h00F);
        bus.blank = 1'b1;
        stepN(2);
        checkOutput("bg_blank", 64'(bus.p_rgb), 64'h000);

        // Empty slot and mid-frame descriptor change
        bus.blank = 1'b0; setObjRgb(0, 12'hFFF);
        stepN(2);
        checkOutput("empty_slot0", 64'(bus.p_rgb), 64'h00F);
        setDesc(0, 26'h0000001);
        stepN(2);
        checkOutput("midframe_no_effect", 64'(bus.p_rgb), 64'h00F);
        frameStart();
        stepN(2);
        checkOutput("slot0_after_frame", 64'(bus.p_rgb), 64'hFFF);

        // Collision on slot 2 in frame N only
        bus.p_obj = '0; setDesc(2, 26'h0000777); bus.obj_rgb = '0; bus.char_rgb = '0;
        frameStart();
        bus.blank = 1'b0; bus.char_rgb = 12'h111; setObjRgb(2, 12'h222);
        applyStimulus();
        bus.char_rgb = '0;
        stepN(4);
        frameStart();
        checkOutput("collide_n1_valid", 64'(bus.collide_valid), 64'd1);
        checkOutput("collide_n1", 64'(bus.collide), 64'b00100);
        applyStimulus();
        checkOutput("collide_pulse_len", 64'(bus.collide_valid), 64'd0);
        stepN(4);
        frameStart();
        checkOutput("collide_n2", 64'(bus.collide), 64'd0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            bus.vsync     = ($urandom_range(0, 6) != 0);
            bus.blank     = ($urandom_range(0, 3) == 0);
            bus.vcount    = 10'($urandom());
            bus.wave_prof = bus.vcount + 10'($urandom_range(0, 4)) - 10'd2;
            bus.char_rgb  = ($urandom_range(0, 2) == 0) ? COLOR_W'($urandom()) : '0;
            bus.sky_rgb   = COLOR_W'($urandom());
            bus.p_vpos    = 10'($urandom());
            bus.obj_en    = NUM_OBJ'($urandom() | $urandom());
            for (int i = 0; i < NUM_OBJ; i++) begin
                setObjRgb(i, ($urandom_range(0, 1) == 0) ? '0 : COLOR_W'($urandom()));
                if ($urandom_range(0, 15) == 0)
                    setDesc(i, ($urandom_range(0, 2) == 0) ? '0 : DESC_W'($urandom()));
            end
            applyStimulus();
        end

        // Partial accumulation dropped by reset
        for (int i = 0; i < NUM_OBJ; i++) begin
            setDesc(i, DESC_W'(i + 1)); setObjRgb(i, 12'h321);
        end
        bus.obj_en = '1;
        frameStart();
        bus.blank = 1'b0; bus.char_rgb = 12'h456;
        stepN(3);
        reset_n = 1'b0;
        stepN(2);
        bus.vsync = 1'b1; bus.blank = 1'b1; bus.char_rgb = '0;
        reset_n = 1'b1;

        // Parallax scroll through a full wrap
        for (int f = 1; f <= 16384; f++) begin
            frameStart();
            if (f == 1) checkOutput("reset_drops_hits", 64'(bus.collide), 64'd0);
            if (f == 16) checkOutput("parallax_16", 64'(bus.parallax_offset), 64'd2);
            if (f == 16376) checkOutput("parallax_max", 64'(bus.parallax_offset), 64'd2047);
            if (f == 16377) checkOutput("parallax_wrap", 64'(bus.parallax_offset), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
